// File: rtl/ins_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder/loader: op classes, opcodes,
// error codes, FSM states and the signed-range helper. ENC_READBACK_EN adds readback states.
package ins_enc_pkg;

  typedef enum logic [2:0] {
    OP_JAL    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_OPIMM  = 3'd4,
    OP_OP     = 3'd5,
    OP_LUI    = 3'd6,
    OP_JALR   = 3'd7
  } ins_op_e;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_LUI   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENCODE = 3'd1,
    ST_WRITE  = 3'd2,
    ST_ERR    = 3'd3
`ifdef ENC_READBACK_EN
    ,
    ST_RB_REQ = 3'd4,
    ST_RB_CHK = 3'd5
`endif
  } enc_state_e;

  // True when v is representable as a two's-complement value of the given width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] sh_s;
    sh_s = $signed(v) >>> (bits - 32'd1);
    return (sh_s == 32'sd0) || (sh_s == -32'sd1);
  endfunction

endpackage

// File: rtl/ins_encoder_loader_if.sv
// Request and IMEM-write bundle of the instruction encoder/loader.
// ENC_READBACK_EN adds the readback signals imem_re, imem_rdata and rb_mismatch.
interface ins_encoder_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [2:0]        req_funct3;
  logic [6:0]        req_funct7;
  logic [31:0]       req_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err_valid;
  logic [1:0]        err_code;
  logic              full;
  logic [ADDR_W:0]   count;
`ifdef ENC_READBACK_EN
  logic              imem_re;
  logic [31:0]       imem_rdata;
  logic              rb_mismatch;

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
    input  imem_rdata,
    output req_ready, imem_we, imem_addr, imem_wdata, err_valid, err_code, full, count,
    output imem_re, rb_mismatch
  );
  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
    output imem_rdata,
    input  req_ready, imem_we, imem_addr, imem_wdata, err_valid, err_code, full, count,
    input  imem_re, rb_mismatch
  );
`else
  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
    output req_ready, imem_we, imem_addr, imem_wdata, err_valid, err_code, full, count
  );
  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
    input  req_ready, imem_we, imem_addr, imem_wdata, err_valid, err_code, full, count
  );
`endif
endinterface

// File: rtl/ins_encoder_loader_imm_pack.sv
// Combinational immediate placement and encodability check for one op class;
// returns only the immediate bits of the word plus the error verdict.
module imm_pack
  import ins_enc_pkg::*;
(
  input  ins_op_e     op,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        err,
  output logic [1:0]  err_code
);

  // Scatter immediate bits per format; alignment takes precedence over range.
  always_comb begin
    imm_bits = 32'd0;
    err_code = ERR_NONE;
    case (op)
      OP_JAL: begin
        imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
        if (imm[0]) err_code = ERR_ALIGN;
        else if (!fits_signed(imm, 32'd21)) err_code = ERR_RANGE;
        else err_code = ERR_NONE;
      end
      OP_BRANCH: begin
        imm_bits = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
        if (imm[0]) err_code = ERR_ALIGN;
        else if (!fits_signed(imm, 32'd13)) err_code = ERR_RANGE;
        else err_code = ERR_NONE;
      end
      OP_STORE: begin
        imm_bits = {imm[11:5], 13'd0, imm[4:0], 7'd0};
        err_code = fits_signed(imm, 32'd12) ? ERR_NONE : ERR_RANGE;
      end
      OP_LOAD, OP_OPIMM, OP_JALR: begin
        imm_bits = {imm[11:0], 20'd0};
        err_code = fits_signed(imm, 32'd12) ? ERR_NONE : ERR_RANGE;
      end
      OP_LUI: begin
        imm_bits = {imm[31:12], 12'd0};
        err_code = (imm[11:0] != 12'd0) ? ERR_LUI : ERR_NONE;
      end
      OP_OP: begin
        imm_bits = 32'd0;
        err_code = ERR_NONE;
      end
      default: begin
        imm_bits = 32'd0;
        err_code = ERR_NONE;
      end
    endcase
  end

  assign err = (err_code != ERR_NONE);

endmodule

// File: rtl/ins_encoder_loader.sv
// RV32I instruction encoder that writes packed words into IMEM at an auto-incrementing
// address. Defining ENC_READBACK_EN adds a read-back-and-compare step after each write.
module ins_encoder_loader
  import ins_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 clear,
  ins_encoder_loader_if.slave bus
);

  localparam logic [ADDR_W:0] BASE_W  = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] LIMIT_W = (ADDR_W+1)'(BASE_ADDR + DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  enc_state_e        state_r, state_s;
  ins_op_e           op_r;
  logic [4:0]        rd_r, rs1_r, rs2_r;
  logic [2:0]        f3_r;
  logic [6:0]        f7_r;
  logic [31:0]       imm_r;
  logic [31:0]       word_r, word_s, imm_bits_s;
  logic [1:0]        ecode_r, pack_code_s;
  logic              pack_err_s, ready_s, xfer_s;
  logic [ADDR_W:0]   addr_r, count_r;
  logic              full_r, imem_we_r, err_valid_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_wdata_r;
  logic [1:0]        err_code_r;

  assign ready_s = (state_r == ST_IDLE) && !full_r;
  assign xfer_s  = bus.req_valid && ready_s;

  imm_pack u_imm_pack (
    .op       (op_r),
    .imm      (imm_r),
    .imm_bits (imm_bits_s),
    .err      (pack_err_s),
    .err_code (pack_code_s)
  );

  // Non-immediate fields of the word; JALR always carries funct3 = 000.
  always_comb begin
    word_s = 32'd0;
    case (op_r)
      OP_JAL:    word_s = {20'd0, rd_r, OPC_JAL};
      OP_BRANCH: word_s = {7'd0, rs2_r, rs1_r, f3_r, 5'd0, OPC_BRANCH};
      OP_LOAD:   word_s = {12'd0, rs1_r, f3_r, rd_r, OPC_LOAD};
      OP_STORE:  word_s = {7'd0, rs2_r, rs1_r, f3_r, 5'd0, OPC_STORE};
      OP_OPIMM:  word_s = {12'd0, rs1_r, f3_r, rd_r, OPC_OPIMM};
      OP_OP:     word_s = {f7_r, rs2_r, rs1_r, f3_r, rd_r, OPC_OP};
      OP_LUI:    word_s = {20'd0, rd_r, OPC_LUI};
      OP_JALR:   word_s = {12'd0, rs1_r, 3'b000, rd_r, OPC_JALR};
      default:   word_s = 32'd0;
    endcase
    word_s = word_s | imm_bits_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   state_s = xfer_s ? ST_ENCODE : ST_IDLE;
      ST_ENCODE: state_s = pack_err_s ? ST_ERR : ST_WRITE;
`ifdef ENC_READBACK_EN
      ST_WRITE:  state_s = ST_RB_REQ;
      ST_RB_REQ: state_s = ST_RB_CHK;
      ST_RB_CHK: state_s = ST_IDLE;
`else
      ST_WRITE:  state_s = ST_IDLE;
`endif
      ST_ERR:    state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State register; rst and clear both abort any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst || clear) state_r <= ST_IDLE;
    else              state_r <= state_s;
  end

  // Request capture, address/count bookkeeping and registered IMEM/error outputs.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      op_r         <= OP_JAL;
      rd_r         <= 5'd0;
      rs1_r        <= 5'd0;
      rs2_r        <= 5'd0;
      f3_r         <= 3'd0;
      f7_r         <= 7'd0;
      imm_r        <= 32'd0;
      word_r       <= 32'd0;
      ecode_r      <= ERR_NONE;
      addr_r       <= BASE_W;
      count_r      <= '0;
      full_r       <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= BASE_W[ADDR_W-1:0];
      imem_wdata_r <= 32'd0;
      err_valid_r  <= 1'b0;
      err_code_r   <= ERR_NONE;
    end else begin
      imem_we_r   <= 1'b0;
      err_valid_r <= 1'b0;
      if (xfer_s) begin
        op_r  <= ins_op_e'(bus.req_op);
        rd_r  <= bus.req_rd;
        rs1_r <= bus.req_rs1;
        rs2_r <= bus.req_rs2;
        f3_r  <= bus.req_funct3;
        f7_r  <= bus.req_funct7;
        imm_r <= bus.req_imm;
      end
      if (state_r == ST_ENCODE) begin
        word_r  <= word_s;
        ecode_r <= pack_code_s;
      end
      if (state_r == ST_WRITE) begin
        imem_we_r    <= 1'b1;
        imem_addr_r  <= addr_r[ADDR_W-1:0];
        imem_wdata_r <= word_r;
        addr_r       <= addr_r + ONE_W;
        count_r      <= count_r + ONE_W;
        full_r       <= ((addr_r + ONE_W) == LIMIT_W);
      end
      if (state_r == ST_ERR) begin
        err_valid_r <= 1'b1;
        err_code_r  <= ecode_r;
      end
    end
  end

  assign bus.req_ready  = ready_s;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign bus.err_valid  = err_valid_r;
  assign bus.err_code   = err_code_r;
  assign bus.full       = full_r;
  assign bus.count      = count_r;

`ifdef ENC_READBACK_EN
  logic imem_re_r, rb_pend_r, rb_mismatch_r;

  // Read request is issued from RB_REQ; memory data arrives one cycle later and is compared then.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      imem_re_r     <= 1'b0;
      rb_pend_r     <= 1'b0;
      rb_mismatch_r <= 1'b0;
    end else begin
      imem_re_r <= (state_r == ST_RB_REQ);
      rb_pend_r <= (state_r == ST_RB_CHK);
      if (rb_pend_r && (bus.imem_rdata != imem_wdata_r)) rb_mismatch_r <= 1'b1;
    end
  end

  assign bus.imem_re     = imem_re_r;
  assign bus.rb_mismatch = rb_mismatch_r;
`endif

endmodule

// File: tb/tb_ins_encoder_loader.sv
// Self-checking bench for ins_encoder_loader: directed plan items then randomized
// requests against a format-level encoding model (readback path when ENC_READBACK_EN).
module tb_ins_encoder_loader;
  import ins_enc_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int DEPTH     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  int   total_checks = 0;
  int   passed_checks = 0;
  int   failed_checks = 0;
  int   m_addr, m_count;
  bit   m_full, m_mis;

  ins_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  ins_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

`ifdef ENC_READBACK_EN
  logic [31:0] mem_q [0:(1<<ADDR_W)-1];
  logic [31:0] corrupt = 32'd0;
  always @(posedge clk) begin
    if (bus.imem_we) mem_q[bus.imem_addr] <= bus.imem_wdata;
    if (bus.imem_re) bus.imem_rdata <= mem_q[bus.imem_addr] ^ corrupt;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else begin
      failed_checks++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32I formats written out field by field; code 0 ok, 1 range, 2 alignment, 3 LUI low bits.
  function automatic void ref_encode(input ins_op_e op, input logic [4:0] rd, rs1, rs2,
                                     input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] v, output logic [31:0] w, output int code);
    int si;
    si = v;
    code = 0;
    case (op)
      OP_JAL: begin
        w = {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
        code = v[0] ? 2 : ((si < -(1 << 20) || si >= (1 << 20)) ? 1 : 0);
      end
      OP_BRANCH: begin
        w = {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
        code = v[0] ? 2 : ((si < -4096 || si > 4095) ? 1 : 0);
      end
      OP_LOAD:  w = {v[11:0], rs1, f3, rd, 7'b0000011};
      OP_STORE: w = {v[11:5], rs2, rs1, f3, v[4:0], 7'b0100011};
      OP_OPIMM: w = {v[11:0], rs1, f3, rd, 7'b0010011};
      OP_OP:    w = {f7, rs2, rs1, f3, rd, 7'b0110011};
      OP_LUI: begin
        w = {v[31:12], rd, 7'b0110111};
        code = (v[11:0] != 12'd0) ? 3 : 0;
      end
      default:  w = {v[11:0], rs1, 3'b000, rd, 7'b1100111};
    endcase
    if (op inside {OP_LOAD, OP_STORE, OP_OPIMM, OP_JALR}) code = (si < -2048 || si > 2047) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_addr  = BASE_ADDR;
    m_count = 0;
    m_full  = 1'b0;
    m_mis   = 1'b0;
  endtask

  task automatic pulse(input bit use_rst);
    @(negedge clk);
    if (use_rst) rst = 1'b1;
    else clear = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear = 1'b0;
    model_reset();
    chk("rst_we", bus.imem_we, 0);
    chk("rst_err_valid", bus.err_valid, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_wdata", bus.imem_wdata, 0);
    chk("rst_addr", bus.imem_addr, BASE_ADDR);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_ready", bus.req_ready, 1);
  endtask

  task automatic drive(input ins_op_e op, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    bus.req_op     = op;
    bus.req_rd     = rd;
    bus.req_rs1    = rs1;
    bus.req_rs2    = rs2;
    bus.req_funct3 = f3;
    bus.req_funct7 = f7;
    bus.req_imm    = imm;
  endtask

  task automatic do_req(input ins_op_e op, input logic [4:0] rd, rs1, rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] exp_w;
    int code, w;
    ref_encode(op, rd, rs1, rs2, f3, f7, imm, exp_w, code);
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", bus.req_ready, 1);
    drive(op, rd, rs1, rs2, f3, f7, imm);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("no_early_out", {bus.imem_we, bus.err_valid}, 0);
    @(negedge clk);
    @(negedge clk);
    if (code == 0) begin
      chk("we", bus.imem_we, 1);
      chk("addr", bus.imem_addr, m_addr);
      chk("wdata", bus.imem_wdata, exp_w);
      chk("err_quiet", bus.err_valid, 0);
      m_addr++;
      m_count++;
      m_full = (m_addr == BASE_ADDR + DEPTH);
    end else begin
      chk("err_valid", bus.err_valid, 1);
      chk("err_code", bus.err_code, code);
      chk("err_no_write", bus.imem_we, 0);
    end
`ifdef ENC_READBACK_EN
    if (code == 0 && corrupt != 32'd0) m_mis = 1'b1;
    repeat (3) @(negedge clk);
    chk("rb_mismatch", bus.rb_mismatch, m_mis);
`endif
    chk("count", bus.count, m_count);
    chk("full", bus.full, m_full);
    chk("ready_after", bus.req_ready, !m_full);
  endtask

  // Abort a transaction with rst/clear during ENCODE (stage 0) or WRITE (stage 1).
  task automatic do_abort(input bit use_rst, input int stage);
    drive(OP_OPIMM, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd7);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (stage + 1) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else clear = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_we", bus.imem_we, 0);
      chk("abort_no_err", bus.err_valid, 0);
      @(negedge clk);
    end
    chk("abort_count", bus.count, 0);
    chk("abort_ready", bus.req_ready, 1);
  endtask

  function automatic logic [31:0] pick_imm();
    case ($urandom_range(0, 13))
      0:       return 32'($urandom_range(0, 15)) << 1;
      1:       return 32'd2047;
      2:       return -32'd2048;
      3:       return 32'd2048;
      4:       return -32'd2049;
      5:       return 32'd4094;
      6:       return -32'd4096;
      7:       return 32'd4096;
      8:       return 32'd1048574;
      9:       return -32'd1048576;
      10:      return 32'd1048576;
      11:      return 32'd3;
      12:      return $urandom & 32'hFFFFF000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.req_valid = 1'b0;
    drive(OP_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(negedge clk);
    pulse(1'b1);

    do_req(OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    do_req(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    do_req(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'd4);
    do_req(OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);

    // Full: a fifth request must be held off.
    drive(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("held_no_we", bus.imem_we, 0);
      chk("held_not_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    pulse(1'b0);

    do_req(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    do_req(OP_OPIMM, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd2048);
    do_req(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd3);
    do_req(OP_LUI, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1001);
    do_req(OP_OP, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 32'hFFFFFFFF);

    do_abort(1'b1, 0);
    do_abort(1'b0, 0);
    do_abort(1'b0, 1);
    do_abort(1'b1, 1);
    do_req(OP_JALR, 5'd1, 5'd2, 5'd0, 3'd5, 7'd0, -32'd2048);

`ifdef ENC_READBACK_EN
    pulse(1'b0);
    corrupt = 32'h0000_0004;
    do_req(OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    corrupt = 32'd0;
`endif

    for (int i = 0; i < 40; i++) begin
      if (m_full) pulse(i[0]);
      do_req(ins_op_e'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), pick_imm());
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/ins_encoder_loader.md
Name: ins_encoder_loader

Overview:
Encoder counterpart to the immediate decoder. It accepts RV32I instruction fields (op class, registers, funct fields, a 32-bit signed immediate) over a valid/ready handshake. It packs them into a 32-bit instruction word and writes that word into instruction memory at an auto-incrementing word address. It is used by the debug/loader path to build test programs in IMEM without an external assembler, and flags immediates that cannot be encoded.

Parameters:
ADDR_W, 8, IMEM word-address width
BASE_ADDR, 0, word address written after reset/clear
DEPTH, 256, number of writable words; the full limit is BASE_ADDR+DEPTH

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
clear  in  1  sync pulse: address back to BASE_ADDR, FSM to IDLE
req_valid  in  1  request fields valid
req_ready  out  1  block can accept a request
req_op  in  3  0 JAL, 1 BRANCH, 2 LOAD, 3 STORE, 4 OPIMM, 5 OP, 6 LUI, 7 JALR
req_rd  in  5  destination register
req_rs1  in  5  source register 1
req_rs2  in  5  source register 2
req_funct3  in  3  funct3 field
req_funct7  in  7  funct7 field, OP only
req_imm  in  32  signed byte offset or value
imem_we  out  1  one-cycle write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded instruction
err_valid  out  1  one-cycle pulse when a request is rejected
err_code  out  2  1 range, 2 alignment, 3 LUI low bits nonzero
full  out  1  address reached BASE_ADDR+DEPTH
count  out  ADDR_W+1  words written since reset/clear

Behaviour:
- Reset or clear: IDLE; address=BASE_ADDR; count=0; imem_we=0; err_valid=0; err_code=0; imem_wdata=0; full=0. clear has the same effect as rst but does not affect in-flight IMEM contents.
- req_ready = (state==IDLE) && !full. Transfer occurs when req_valid && req_ready; the fields are registered on that edge.
- State ENCODE, one cycle:
  - Pack the word and run the checks.
  - JAL: imm must fit signed 21 bits and imm[0]=0.
  - BRANCH: signed 13 bits, imm[0]=0.
  - LOAD, STORE, OPIMM, JALR: signed 12 bits.
  - LUI: imm[11:0]=0, with imm[31:12] placed in bits 31:12.
  - OP: imm ignored; funct7 goes in bits 31:25.
  - Opcodes: 1101111, 1100011, 0000011, 0100011, 0010011, 0110011, 0110111, 1100111.
  - JALR funct3 is forced to 000.
- ENCODE -> WRITE on pass. ENCODE -> ERR on fail; alignment is checked before range.
- WRITE, one cycle: imem_we=1 with address and word; afterwards address+1 and count+1, then -> IDLE.
- ERR, one cycle: err_valid=1 and err_code is held until the next error or reset; no write, address unchanged; -> IDLE.
- Latency: transfer edge to imem_we high is 2 cycles; throughput is one instruction per 3 cycles.
- full is set when address == BASE_ADDR+DEPTH after a write; req_ready stays low until clear/rst. The last word is written normally and there is no wrap-around.
- clear or rst in ENCODE, WRITE or ERR aborts immediately: no write, no error pulse. rst has priority over clear.

Optional Feature:
- ENC_READBACK_EN defined:
  - Adds ports imem_re (out 1), imem_rdata (in 32, valid 1 cycle after imem_re), rb_mismatch (out 1 sticky).
  - After WRITE, states RB_REQ (imem_re=1) and RB_CHK compare imem_rdata with the written word; a mismatch sets rb_mismatch.
  - Throughput becomes 5 cycles.
- Undefined: the ports and states are absent, and rb_mismatch logic is removed.

Decomposition:
- Package ins_enc_pkg: opcode constants, req_op encoding, err_code constants, state enum.
- One sub-module, imm_pack: combinational; (req_op, imm) -> immediate bit placement plus the err/err_code result. It is reused by ENCODE.

Test Plan:
- OPIMM rd=1 rs1=0 f3=0 imm=5 -> imem_we at 0x00 with 0x00500093, count=1.
- JAL rd=1 imm=8 -> 0x008000EF; BRANCH rs1=1 rs2=2 f3=0 imm=-4 -> 0xFE208EE3 at consecutive addresses.
- STORE rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423; LUI rd=5 imm=0x12345000 -> 0x123452B7.
- Error cases, each with no write and address unchanged:
  - OPIMM imm=2048 -> err_valid, code 1.
  - BRANCH imm=3 -> code 2.
  - LUI imm=0x1001 -> code 3.
- DEPTH=4: write 4 words -> full=1, req_ready=0, a 5th request is held; clear -> address=BASE_ADDR, count=0, req_ready=1.
- Assert rst the cycle after a transfer -> no imem_we, address=BASE_ADDR; with ENC_READBACK_EN, force a corrupt imem_rdata -> rb_mismatch=1.
